// File: rtl/intc_if.sv
// Signal bundle between the core and interrupt_controller.
// The core drives requests and control; the controller returns redirect and state.
interface intc_if #(
  parameter int CHANNELS = 3,
  parameter int ID_WIDTH = 2
);
  logic [CHANNELS-1:0] irq_in;
  logic                mask_we;
  logic [CHANNELS-1:0] mask_wdata;
  logic                stall;
  logic                eret;
  logic [31:0]         pc_next;
  logic                redirect;
  logic [31:0]         redirect_pc;
  logic                take;
  logic [31:0]         epc;
  logic                ie;
  logic [ID_WIDTH-1:0] active_id;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] mask;

  modport master (
    output irq_in, mask_we, mask_wdata, stall, eret, pc_next,
    input  redirect, redirect_pc, take, epc, ie, active_id, pending, mask
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, stall, eret, pc_next,
    output redirect, redirect_pc, take, epc, ie, active_id, pending, mask
  );
endinterface

// File: rtl/interrupt_controller.sv
// Vectored, non-nesting interrupt controller: synchronises and edge-detects requests,
// latches them as pending, vectors to the highest-priority unmasked one and returns via eret.
module interrupt_controller #(
  parameter int          CHANNELS      = 3,
  parameter int          ID_WIDTH      = 2,
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0800,
  parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0020
) (
  input logic   clk,
  input logic   rst_n,
  intc_if.slave bus
);

  typedef enum logic {
    SERVICE = 1'b0,
    IDLE    = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] s1_q, s2_q, s3_q;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [31:0]         epc_q, epc_d;
  logic [ID_WIDTH-1:0] active_id_q, active_id_d;

  logic [CHANNELS-1:0] rise_s;
  logic [CHANNELS-1:0] req_s;
  logic [CHANNELS-1:0] clr_s;
  logic [ID_WIDTH-1:0] sel_id_s;
  logic                take_s;
  logic                eret_ok_s;
  logic [31:0]         vector_s;
  logic                redirect_s;
  logic [31:0]         redirect_pc_s;

  assign rise_s    = s2_q & ~s3_q;
  assign req_s     = pending_q & ~mask_q;
  assign take_s    = (state_q == IDLE) & ~bus.stall & ~bus.eret & (|req_s);
  assign eret_ok_s = bus.eret & (state_q == SERVICE) & ~bus.stall;
  assign vector_s  = VECTOR_BASE + (32'(sel_id_s) * VECTOR_STRIDE);

  // Scan from the top down so the lowest-index request is the one left standing.
  always_comb begin
    sel_id_s = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (req_s[i]) begin
        sel_id_s = ID_WIDTH'(i);
      end else begin
        sel_id_s = sel_id_s;
      end
    end
  end

  // Clear only the channel being taken; a fresh rise in the same cycle re-sets it below.
  always_comb begin
    clr_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      clr_s[i] = take_s & (sel_id_s == ID_WIDTH'(i));
    end
  end

  // Next-state and datapath update for pending, mask, epc and active_id.
  always_comb begin
    pending_d   = (pending_q & ~clr_s) | rise_s;
    mask_d      = mask_q;
    epc_d       = epc_q;
    active_id_d = active_id_q;
    if (bus.mask_we) begin
      mask_d = bus.mask_wdata;
    end else begin
      mask_d = mask_q;
    end
    if (take_s) begin
      epc_d       = bus.pc_next;
      active_id_d = sel_id_s;
    end else begin
      epc_d       = epc_q;
      active_id_d = active_id_q;
    end
  end

  // Service state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Service state transitions: take enters service, an accepted eret leaves it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_s) state_d = SERVICE;
        else        state_d = IDLE;
      end
      SERVICE: begin
        if (eret_ok_s) state_d = IDLE;
        else           state_d = SERVICE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Redirect outputs; take and eret_ok are mutually exclusive since they need opposite ie.
  always_comb begin
    redirect_s    = 1'b0;
    redirect_pc_s = epc_q;
    case (state_q)
      IDLE: begin
        redirect_s = take_s;
        if (take_s) redirect_pc_s = vector_s;
        else        redirect_pc_s = epc_q;
      end
      SERVICE: begin
        redirect_s    = eret_ok_s;
        redirect_pc_s = epc_q;
      end
      default: begin
        redirect_s    = 1'b0;
        redirect_pc_s = epc_q;
      end
    endcase
  end

  // Synchroniser, edge-detect stage and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      epc_q       <= 32'h0000_0000;
      active_id_q <= '0;
    end else begin
      s1_q        <= bus.irq_in;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      epc_q       <= epc_d;
      active_id_q <= active_id_d;
    end
  end

  assign bus.take        = take_s;
  assign bus.redirect    = redirect_s;
  assign bus.redirect_pc = redirect_pc_s;
  assign bus.epc         = epc_q;
  assign bus.ie          = (state_q == IDLE);
  assign bus.active_id   = active_id_q;
  assign bus.pending     = pending_q;
  assign bus.mask        = mask_q;

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Parametrised vectored interrupt controller for the single-cycle MIPS core, generalising the fixed three-source priority/mask/disable logic to CHANNELS sources. It synchronises and edge-detects external requests, latches them as pending, selects the highest-priority unmasked request, redirects the PC to a per-channel vector and saves the return address in EPC. It adds software masking, per-channel vectors and an `eret` return path that restores the PC from EPC and re-enables interrupts.

## Interface
- CHANNELS, 3, number of interrupt sources (1..16)
- ID_WIDTH, 2, width of channel id; 2**ID_WIDTH >= CHANNELS
- VECTOR_BASE, 32'h0000_0800, entry address of channel 0
- VECTOR_STRIDE, 32'h0000_0020, byte spacing between channel entries
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- irq_in  in  CHANNELS  raw request lines, asynchronous to clk, rising edge = request
- mask_we  in  1  write enable for mask register
- mask_wdata  in  CHANNELS  new mask; bit=1 blocks that channel
- stall  in  1  core halted; no interrupt is taken while high
- eret  in  1  core is executing return-from-interrupt this cycle
- pc_next  in  32  address the core would execute next; saved as EPC on take
- redirect  out  1  core must load redirect_pc instead of pc_next this cycle
- redirect_pc  out  32  vector address on take, EPC on accepted eret
- take  out  1  an interrupt is accepted this cycle
- epc  out  32  saved return address
- ie  out  1  interrupt enable (0 = in service)
- active_id  out  ID_WIDTH  channel currently/last serviced
- pending  out  CHANNELS  latched pending requests
- mask  out  CHANNELS  current mask register

## Operation
- Per channel: two-flop synchroniser s1→s2, plus s3 <= s2; rise = s2 & ~s3.
- pending[i] <= (pending[i] & ~clr[i]) | rise[i]; clr[i] = take & (sel_id==i). Set wins over clear in the same cycle.
- req = pending & ~mask; sel_id = lowest index set in req (channel 0 highest priority).
- take = ie & ~stall & ~eret & |req (combinational).
- eret_ok = eret & ~ie & ~stall; eret while ie==1 is ignored (no redirect, no state change).
- redirect = take | eret_ok; redirect_pc = take ? VECTOR_BASE + sel_id*VECTOR_STRIDE : epc (32-bit unsigned, wraps mod 2**32).
- On take edge: epc <= pc_next, ie <= 0, active_id <= sel_id, pending[sel_id] cleared.
- On eret_ok edge: ie <= 1; epc, active_id unchanged.
- mask_we: mask <= mask_wdata at edge; take in that cycle uses the old mask.
- No nesting: while ie==0, new requests only accumulate in pending.
- States (implicit in ie): IDLE (ie=1) –take→ SERVICE (ie=0) –eret_ok→ IDLE.

## Timing
- Reset (async, rst_n low): s1/s2/s3=0, pending=0, mask=0, ie=1, epc=0, active_id=0; hence take=0, redirect=0, redirect_pc=VECTOR_BASE... when no take: redirect_pc=epc=0.
- Reset release is synchronous to next clk edge for new state updates; reset mid-service returns to IDLE with all pending dropped.
- Latency: irq_in rising before edge E1 → s2=1 after E2 → pending set at E3 → take high in cycle after E3 (if ie, unmasked, no stall) → state updated at E4.
- A request must stay high ≥2 clk periods to be reliably captured; a level held high generates exactly one request.
- Masked pending requests remain pending; unmasking makes them eligible the cycle after the mask write.
- stall high: take and eret_ok forced 0, pending still accumulates.
- Simultaneous eret_ok and pending request: eret wins; take occurs the following cycle (back-to-back), epc <= pc_next of that cycle.

## Test plan
- Reset: rst_n low mid-run with pending=3'b101, ie=0 → all outputs zero except ie=1, immediately (asynchronous).
- Single request: pulse irq_in[1] for 2 cycles, pc_next=32'h0000_0040 → take 3 edges later, redirect_pc=32'h0000_0820, then epc=32'h40, ie=0, active_id=1, pending=0.
- Priority: irq_in=3'b110 together → channel 1 taken first (vector 32'h820); after eret, channel 2 taken next cycle (vector 32'h840).
- Mask: mask=3'b001, pulse irq_in[0] → pending[0]=1, no take; write mask=0 → take next cycle, redirect_pc=32'h800.
- eret: in service with epc=32'h100, assert eret → redirect=1, redirect_pc=32'h100, ie=1; eret with ie=1 → redirect=0.
- Stall/hold: stall=1 with pending unmasked → take=0 for all stall cycles; stall=0 → take same cycle; irq held high 20 cycles → exactly one take.
